ram_loader: RTL
===============

Name: ram_loader

Overview:
- Initiator for the RAM programming interface. It takes a stream of bytes over a valid/ready handshake and writes them into all RAM addresses, from address 0 to DEPTH-1.
- It drives the RAM's program-mode address/data inputs and its active-low write_enable.
- When VERIFY=1 it then reads every address back over bus_out and compares a checksum.
- It sits between a host/UART byte source and the ram block, and replaces manual dipswitch programming.

Parameters:
- DATA_W, 8, data byte width
- ADDR_W, 4, RAM address width
- DEPTH, 16, number of locations written (<= 2**ADDR_W)
- WE_PULSE, 1, cycles write_enable is held low per write (>= 1)
- VERIFY, 1, 1 = run read-back checksum phase after writes

Ports:
- clk  input  1  system clock, rising edge
- clear_n  input  1  asynchronous active-low reset
- start  input  1  begin load sequence; sampled only in IDLE
- byte_in  input  DATA_W  byte to write
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts byte this cycle
- ram_rdata  input  DATA_W  RAM bus_out, used for read-back
- prog_mode  output  1  1 = RAM uses the loader address/data (program path)
- ram_addr  output  ADDR_W  to RAM dipswitch_addr
- ram_data  output  DATA_W  to RAM dipswitch_data
- write_enable  output  1  active-low RAM write strobe
- output_enable  output  1  RAM read enable onto bus_out
- busy  output  1  sequence in progress
- done  output  1  sequence complete; held until next start
- error  output  1  checksum mismatch; valid when done=1
- checksum  output  DATA_W  running modulo-2**DATA_W sum of written bytes

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state = IDLE
  - prog_mode = 0, write_enable = 1, output_enable = 0, byte_ready = 0
  - busy = 0, done = 0, error = 0
  - ram_addr = 0, ram_data = 0, checksum = 0, read sum = 0
  - Reset asserted mid-write releases write_enable high immediately. No partial sequence is resumed.
- All outputs are registered. write_enable never glitches low outside the WRITE state.
- IDLE:
  - start=1 -> WAIT_BYTE on the next edge.
  - At that edge: busy = 1, done = 0, error = 0, prog_mode = 1, ram_addr = 0, checksum = 0.
  - start while busy is ignored.
- WAIT_BYTE:
  - byte_ready = 1.
  - Transfer occurs on an edge where byte_valid && byte_ready.
  - At the transfer edge: ram_data <= byte_in, checksum <= checksum + byte_in, byte_ready <= 0, state -> SETUP.
  - With no valid byte, the loader waits indefinitely.
- SETUP: 1 cycle; address and data are stable with write_enable high. Next state is WRITE with write_enable <= 0.
- WRITE: write_enable is low for exactly WE_PULSE cycles, then HOLD with write_enable <= 1.
- HOLD: 1 cycle; address and data are still stable.
  - If ram_addr == DEPTH-1: go to VREAD (VERIFY=1) or FINISH (VERIFY=0).
  - Otherwise ram_addr <= ram_addr + 1 and return to WAIT_BYTE.
- Per-byte timing:
  - Minimum write cost is WE_PULSE+2 cycles after the transfer edge.
  - With WE_PULSE=1, write_enable is low during the 2nd cycle after transfer.
- VREAD (VERIFY=1):
  - Entry sets ram_addr <= 0, read sum <= 0, prog_mode = 1, output_enable <= 1.
  - Each address takes 2 cycles: ADDR cycle (address settles), then SAMPLE cycle (read sum += ram_rdata).
  - After sampling DEPTH-1, go to FINISH with output_enable <= 0.
- FINISH: 1 cycle.
  - error <= (VERIFY && read sum != checksum).
  - busy <= 0, prog_mode <= 0, done <= 1, state -> IDLE.
- Wrap: ram_addr never exceeds DEPTH-1. Checksum and read sum wrap modulo 2**DATA_W.
- byte_valid outside WAIT_BYTE is ignored; no byte is consumed.

Test Plan:
1. Reset mid-write:
   - Stimulus: drive clear_n=0 during the WRITE state.
   - Response: write_enable = 1 asynchronously, busy = 0, state = IDLE; after release, byte_ready = 0 until start.
2. Full load, VERIFY=0, WE_PULSE=1:
   - Stimulus: start, then bytes 0x00..0x0F, byte_valid always high.
   - Response: exactly 16 write_enable low pulses of 1 cycle each, at ram_addr 0..F with ram_data matching; checksum = 0x78; done = 1, error = 0.
3. Handshake stall:
   - Stimulus: byte_valid low for 5 cycles in WAIT_BYTE, then byte 0xCF.
   - Response: byte_ready stays high and write_enable stays high during the stall; 0xCF is written once at the current address.
4. Verify pass:
   - Stimulus: behavioural RAM model, 16 bytes all 0xF7.
   - Response: output_enable high for 32 cycles; checksum = 0x70; error = 0.
5. Verify fail:
   - Stimulus: RAM model corrupts address 5 on read (0x01 instead of 0x05), bytes 0x00..0x0F.
   - Response: done = 1, error = 1.
6. Start while busy and WE_PULSE=3:
   - Stimulus: pulse start mid-sequence.
   - Response: the sequence continues unchanged; each write_enable low pulse is exactly 3 cycles.

Source files
------------

// File: rtl/ram_loader_if.sv
// ram_loader_if: groups the byte-stream handshake and the RAM program/read
// bus that the loader drives.
//   byte_in/byte_valid/byte_ready : valid/ready byte stream from the host
//   ram_rdata                     : RAM bus_out, sampled during read-back
//   prog_mode                     : RAM takes address/data from the loader
//   ram_addr/ram_data             : RAM dipswitch_addr / dipswitch_data
//   write_enable                  : active-low RAM write strobe
//   output_enable                 : RAM read enable onto bus_out
// master = the loader, slave = the byte source and RAM side.
interface ram_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [DATA_W-1:0] ram_rdata;
    logic              prog_mode;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              write_enable;
    logic              output_enable;

    modport master (
        input  byte_in, byte_valid, ram_rdata,
        output byte_ready, prog_mode, ram_addr, ram_data, write_enable, output_enable
    );

    modport slave (
        output byte_in, byte_valid, ram_rdata,
        input  byte_ready, prog_mode, ram_addr, ram_data, write_enable, output_enable
    );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: programs every RAM location 0..DEPTH-1 from a valid/ready byte
// stream, then optionally reads the whole RAM back and compares a checksum.
// Ports:
//   clk      : system clock, rising edge
//   clear_n  : asynchronous active-low reset
//   start    : begins a load sequence, sampled only while idle
//   bus      : ram_loader_if.master (byte stream in, RAM program/read bus out)
//   busy     : sequence in progress
//   done     : sequence complete, held until the next start
//   error    : read-back sum differs from checksum, valid while done=1
//   checksum : modulo-2**DATA_W sum of all bytes written
// Every output is a register, so write_enable cannot glitch.
module ram_loader #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int WE_PULSE = 1,
    parameter int VERIFY   = 1
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    ram_loader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = (WE_PULSE > 1) ? $clog2(WE_PULSE) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WE_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_VADDR,
        S_VSAMPLE,
        S_FINISH
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  we_cnt;
    logic [DATA_W-1:0] read_sum;
    logic              byte_ready;
    logic              prog_mode;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              write_enable;
    logic              output_enable;

    // Both sums deliberately wrap; the carry out is discarded.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign bus.byte_ready    = byte_ready;
    assign bus.prog_mode     = prog_mode;
    assign bus.ram_addr      = ram_addr;
    assign bus.ram_data      = ram_data;
    assign bus.write_enable  = write_enable;
    assign bus.output_enable = output_enable;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state         <= S_IDLE;
            we_cnt        <= '0;
            read_sum      <= '0;
            byte_ready    <= 1'b0;
            prog_mode     <= 1'b0;
            ram_addr      <= '0;
            ram_data      <= '0;
            write_enable  <= 1'b1;
            output_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            checksum      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_WAIT_BYTE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        prog_mode  <= 1'b1;
                        ram_addr   <= '0;
                        checksum   <= '0;
                        byte_ready <= 1'b1;
                    end
                end

                S_WAIT_BYTE: begin
                    // byte_ready is only ever high here, so bytes offered in
                    // any other state are left untouched at the source.
                    if (bus.byte_valid && byte_ready) begin
                        ram_data   <= bus.byte_in;
                        checksum   <= wrap_add(checksum, bus.byte_in);
                        byte_ready <= 1'b0;
                        state      <= S_SETUP;
                    end
                end

                // Address and data have one full cycle to settle before the strobe.
                S_SETUP: begin
                    write_enable <= 1'b0;
                    we_cnt       <= '0;
                    state        <= S_WRITE;
                end

                S_WRITE: begin
                    if (we_cnt == LAST_CNT) begin
                        write_enable <= 1'b1;
                        state        <= S_HOLD;
                    end else begin
                        we_cnt <= we_cnt + 1'b1;
                    end
                end

                // Address and data stay put one cycle after the strobe rises.
                S_HOLD: begin
                    if (ram_addr == LAST_ADDR) begin
                        if (VERIFY != 0) begin
                            ram_addr      <= '0;
                            read_sum      <= '0;
                            output_enable <= 1'b1;
                            state         <= S_VADDR;
                        end else begin
                            state <= S_FINISH;
                        end
                    end else begin
                        ram_addr   <= ram_addr + 1'b1;
                        byte_ready <= 1'b1;
                        state      <= S_WAIT_BYTE;
                    end
                end

                // Read-back: one cycle for the RAM output to settle, one to sample.
                S_VADDR: begin
                    state <= S_VSAMPLE;
                end

                S_VSAMPLE: begin
                    read_sum <= wrap_add(read_sum, bus.ram_rdata);
                    if (ram_addr == LAST_ADDR) begin
                        output_enable <= 1'b0;
                        state         <= S_FINISH;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                        state    <= S_VADDR;
                    end
                end

                S_FINISH: begin
                    error     <= (VERIFY != 0) && (read_sum != checksum);
                    busy      <= 1'b0;
                    prog_mode <= 1'b0;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
